// File: rtl/uart_pkg.sv
// Shared UART framing definitions for the transmitter and the trigger-side receiver.
package uart_pkg;

  localparam int          DATA_BITS = 8;
  localparam logic [15:0] MIN_BAUD  = 16'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    START = S_START,
    DATA  = S_DATA,
    STOP  = S_STOP
  } tx_state_t;

  // Bit periods below two cycles cannot be decoded by the receiver, so clamp them.
  function automatic logic [15:0] eff_period(input logic [15:0] raw);
    return (raw < MIN_BAUD) ? MIN_BAUD : raw;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding the UART transmitter: synchronous FIFO with same-cycle push/pop.
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/prot_uart_tx.sv
// UART 8N1 transmitter driving a channel line from an internal byte buffer.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); last cycle pulses tx_done and may chain the next frame
module prot_uart_tx
  import uart_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    baud_cntH,
  input  logic [7:0]    baud_cntL,
  input  logic [7:0]    tx_data,
  input  logic          wr_en,
  input  logic          clr_ovf,
  output logic          TX,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          overflow
);

  tx_state_t   r_state;
  tx_state_t   w_state_nx;
  logic [15:0] r_period;
  logic [15:0] w_period_nx;
  logic [15:0] r_baud;
  logic [15:0] w_baud_nx;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nx;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nx;
  logic        r_tx;
  logic        w_tx_nx;
  logic        r_ovf;

  logic [15:0] w_period;
  logic        w_bit_end;
  logic        w_load;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [7:0]  w_head;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;

  assign w_period  = eff_period({baud_cntH, baud_cntL});
  assign w_bit_end = (r_baud == 16'd0);
  assign w_push    = wr_en && (!w_full || w_pop);
  assign w_drop    = wr_en && w_full && !w_pop;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (tx_data),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next-state logic: frame sequencing, baud down-counter and shift register.
  always_comb begin
    w_state_nx  = r_state;
    w_period_nx = r_period;
    w_shift_nx  = r_shift;
    w_bit_nx    = r_bit;
    w_baud_nx   = (r_baud != 16'd0) ? r_baud - 16'd1 : r_baud;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) w_load = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nx = DATA;
          w_baud_nx  = r_period - 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nx = r_period - 16'd1;
          if (r_bit == 3'(DATA_BITS - 1)) begin
            w_state_nx = STOP;
          end else begin
            w_shift_nx = r_shift >> 1;
            w_bit_nx   = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) w_load = 1'b1;
          else          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    // Frame start: the bit period is captured here so mid-frame register writes wait a frame.
    if (w_load) begin
      w_pop       = 1'b1;
      w_state_nx  = START;
      w_shift_nx  = w_head;
      w_period_nx = w_period;
      w_bit_nx    = 3'd0;
      w_baud_nx   = w_period - 16'd1;
    end
  end

  // Line level follows the state entered at this edge so TX is a clean register output.
  always_comb begin
    unique case (w_state_nx)
      START:   w_tx_nx = 1'b0;
      DATA:    w_tx_nx = w_shift_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

  // State registers, line register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_period <= MIN_BAUD;
      r_baud   <= 16'd0;
      r_bit    <= 3'd0;
      r_shift  <= 8'd0;
      r_tx     <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_period <= w_period_nx;
      r_baud   <= w_baud_nx;
      r_bit    <= w_bit_nx;
      r_shift  <= w_shift_nx;
      r_tx     <= w_tx_nx;
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign TX       = r_tx;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = w_count;
  assign tx_busy  = (r_state != IDLE);
  assign tx_done  = (r_state == STOP) && w_bit_end;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_prot_uart_tx.sv
// Self-checking bench for prot_uart_tx: table vectors, corner sequences, random bursts.
module tb_prot_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] baud_cntH;
  logic [7:0] baud_cntL;
  logic [7:0] tx_data;
  logic       wr_en;
  logic       clr_ovf;
  logic       TX;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       tx_busy;
  logic       tx_done;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  prot_uart_tx #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_cntH (baud_cntH),
    .baud_cntL (baud_cntL),
    .tx_data   (tx_data),
    .wr_en     (wr_en),
    .clr_ovf   (clr_ovf),
    .TX        (TX),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required finish within 1 ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] raw;
    int          exp_p;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference line level of an 8N1 frame at cycle k for bit period p.
  function automatic logic exp_tx(input logic [7:0] d, input int p, input int k);
    int pos;
    pos = k / p;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    return 1'b1;
  endfunction

  // Compares nb contiguous frames cycle by cycle; first call tick lands on the frame start edge.
  task automatic check_frames(input logic [7:0] b[8], input int nb, input int pp[8],
                              output int wave_err, output int done_err, output logic [2:0] cf[8]);
    wave_err = 0;
    done_err = 0;
    for (int i = 0; i < 8; i++) cf[i] = '0;
    for (int f = 0; f < nb; f++) begin
      for (int k = 0; k < 10 * pp[f]; k++) begin
        tick();
        if (k == 0) cf[f] = count;
        if (TX !== exp_tx(b[f], pp[f], k) || tx_busy !== 1'b1) wave_err++;
        if (tx_done !== (k == 10 * pp[f] - 1)) done_err++;
      end
    end
  endtask

  task automatic run_burst(input logic [7:0] b[8], input int nb, input logic [15:0] raw, input int p,
                           output int wave_err, output int done_err,
                           output logic [2:0] cnt_w, output logic [2:0] cf[8]);
    int pp[8];
    for (int i = 0; i < 8; i++) pp[i] = p;
    baud_cntH = raw[15:8];
    baud_cntL = raw[7:0];
    tx_data   = b[0];
    wr_en     = 1'b1;
    tick();
    fork
      begin
        for (int i = 1; i < nb; i++) begin
          tx_data = b[i];
          tick();
        end
        wr_en = 1'b0;
        cnt_w = count;
      end
      check_frames(b, nb, pp, wave_err, done_err, cf);
    join
  endtask

  // Line-level receiver: waits for a start bit, then samples mid-bit.
  task automatic rx_byte(input int p, output logic [7:0] d, output logic ok);
    int t;
    t  = 0;
    ok = 1'b1;
    d  = '0;
    while (TX !== 1'b0 && t < 2000) begin
      tick();
      t++;
    end
    if (t >= 2000) ok = 1'b0;
    repeat (p / 2) tick();
    if (TX !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (p) tick();
      d[i] = TX;
    end
    repeat (p) tick();
    if (TX !== 1'b1) ok = 1'b0;
  endtask

  vec_t        vecs[6];
  logic [7:0]  bb[8];
  logic [2:0]  cf[8];
  logic [2:0]  cnt_w;
  int          werr;
  int          derr;
  int          pp2[8];
  int          bad;
  logic [7:0]  rxd;
  logic        rxok;
  logic [7:0]  ovf_exp[5];
  logic [15:0] raw;
  int          nb;
  int          pe;
  logic        found;

  initial begin
    vecs[0] = '{data: 8'hA5, raw: 16'd4,     exp_p: 4};
    vecs[1] = '{data: 8'h3C, raw: 16'd0,     exp_p: 2};
    vecs[2] = '{data: 8'hC3, raw: 16'd1,     exp_p: 2};
    vecs[3] = '{data: 8'h5A, raw: 16'd3,     exp_p: 3};
    vecs[4] = '{data: 8'h01, raw: 16'd2,     exp_p: 2};
    vecs[5] = '{data: 8'h81, raw: 16'h0100,  exp_p: 256};

    rst = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0; tx_data = '0;
    baud_cntH = '0; baud_cntL = 8'd4;
    tick(); tick();
    check("reset_tx",    TX,       1'b1);
    check("reset_full",  full,     1'b0);
    check("reset_empty", empty,    1'b1);
    check("reset_count", count,    3'd0);
    check("reset_busy",  tx_busy,  1'b0);
    check("reset_done",  tx_done,  1'b0);
    check("reset_ovf",   overflow, 1'b0);
    rst = 1'b0;
    tick();

    // Table: single frames from idle across bit periods, including clamped 0 and 1.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) bb[i] = '0;
      bb[0] = vecs[v].data;
      run_burst(bb, 1, vecs[v].raw, vecs[v].exp_p, werr, derr, cnt_w, cf);
      check($sformatf("vec%0d_wave", v), werr, 0);
      check($sformatf("vec%0d_done", v), derr, 0);
      check($sformatf("vec%0d_cnt_at_start", v), cf[0], 3'd0);
      tick();
      check($sformatf("vec%0d_idle_busy", v), tx_busy, 1'b0);
      check($sformatf("vec%0d_idle_tx", v), TX, 1'b1);
    end

    // Back-to-back frames: 0x00, 0xFF, 0x55 at P=3.
    bb = '{8'h00, 8'hFF, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst(bb, 3, 16'd3, 3, werr, derr, cnt_w, cf);
    check("b2b_wave", werr, 0);
    check("b2b_done", derr, 0);
    check("b2b_cnt_after_writes", cnt_w, 3'd2);
    check("b2b_cnt_frame1", cf[1], 3'd1);
    check("b2b_cnt_frame2", cf[2], 3'd0);
    tick();
    check("b2b_idle_busy", tx_busy, 1'b0);

    // Mid-frame bit-period change: current frame keeps P=4, next frame uses P=8.
    baud_cntH = '0; baud_cntL = 8'd4;
    bb = '{8'h96, 8'h69, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) pp2[i] = 4;
    pp2[1] = 8;
    tx_data = bb[0]; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    fork
      check_frames(bb, 2, pp2, werr, derr, cf);
      begin
        repeat (10) tick();
        baud_cntL = 8'd8;
        tx_data = bb[1]; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
      end
    join
    check("baudchg_wave", werr, 0);
    check("baudchg_done", derr, 0);
    tick();

    // Overflow: fill the buffer during a long frame, then drop, clear, and write on a pop.
    baud_cntH = '0; baud_cntL = 8'd20;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'h10 + 8'(i);
      tick();
    end
    check("ovf_full_after_fill", full, 1'b1);
    check("ovf_count_after_fill", count, 3'd4);
    check("ovf_flag_before_drop", overflow, 1'b0);
    tx_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("ovf_set_on_drop", overflow, 1'b1);
    check("ovf_count_after_drop", count, 3'd4);
    repeat (3) tick();
    check("ovf_sticky", overflow, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    wr_en = 1'b1; tx_data = 8'hDD; clr_ovf = 1'b1;
    tick();
    wr_en = 1'b0; clr_ovf = 1'b0;
    check("ovf_set_beats_clear", overflow, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      if (tx_done === 1'b1) found = 1'b1;
      else tick();
    end
    check("ovf_wait_done", found, 1'b1);
    wr_en = 1'b1; tx_data = 8'h77;
    tick();
    wr_en = 1'b0;
    check("ovf_pop_push_count", count, 3'd4);
    check("ovf_pop_push_full", full, 1'b1);
    check("ovf_pop_push_flag", overflow, 1'b0);
    ovf_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h77};
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      rx_byte(20, rxd, rxok);
      if (!rxok || rxd !== ovf_exp[i]) begin
        bad++;
        $display("FAIL ovf_rx_byte%0d: got %0h (framing ok=%0b), required %0h", i, rxd, rxok, ovf_exp[i]);
      end
    end
    check("ovf_rx_sequence", bad, 0);
    repeat (20) tick();
    check("ovf_drain_busy", tx_busy, 1'b0);
    check("ovf_drain_empty", empty, 1'b1);

    // Reset during DATA bit 3 with another byte waiting.
    baud_cntL = 8'd4;
    wr_en = 1'b1; tx_data = 8'h00;
    tick();
    tx_data = 8'h42;
    tick();
    wr_en = 1'b0;
    repeat (17) tick();
    check("rst_mid_line_low", TX, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_tx", TX, 1'b1);
    check("rst_mid_empty", empty, 1'b1);
    check("rst_mid_count", count, 3'd0);
    check("rst_mid_busy", tx_busy, 1'b0);
    check("rst_mid_done", tx_done, 1'b0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_done !== 1'b0 || TX !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("rst_mid_quiet_after", bad, 0);

    // Random bursts of 1..3 bytes with random raw periods 0..6.
    for (int r = 0; r < 10; r++) begin
      nb  = int'($urandom_range(1, 3));
      raw = 16'($urandom_range(0, 6));
      pe  = (raw < 16'd2) ? 2 : int'(raw);
      for (int i = 0; i < 8; i++) bb[i] = 8'($urandom);
      run_burst(bb, nb, raw, pe, werr, derr, cnt_w, cf);
      check($sformatf("rnd%0d_wave", r), werr, 0);
      check($sformatf("rnd%0d_done", r), derr, 0);
      check($sformatf("rnd%0d_cnt", r), cnt_w, (nb == 1) ? 3'd1 : 3'(nb - 1));
      tick();
      check($sformatf("rnd%0d_idle", r), tx_busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
